csr_reg: RTL and testbench
==========================

CSR_REG -- requirements
Module: csr_reg

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- csr_wen_i  in  1  writeback-stage CSR write enable
- csr_waddr_i  in  32  CSR write address; only [11:0] is decoded
- csr_wdata_i  in  32  CSR write data
- csr_raddr_i  in  32  CSR read address from decode; only [11:0] is decoded
- csr_rdata_o  out  32  CSR read data, combinational
- retire_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry pulse
- trap_pc_i  in  32  PC to save on trap
- trap_cause_i  in  32  cause to save on trap
- mret_i  in  1  MRET executed
- mtvec_o  out  32  current mtvec
- mepc_o  out  32  current mepc
- mie_o  out  1  mstatus.MIE

Function
REQ-002 The decoded register set SHALL be:
- mstatus 0x300
- misa 0x301, read-only 0x40000100
- mie 0x304
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mtval 0x343
- mcycle/mcycleh 0xB00/0xB80
- minstret/minstreth 0xB02/0xB82
- cycle/cycleh 0xC00/0xC80, read-only aliases
- instret/instreth 0xC02/0xC82, read-only aliases
REQ-003 Unmapped addresses SHALL read 0; writes to them SHALL be ignored; writes to read-only CSRs SHALL be ignored.
REQ-004 mstatus SHALL implement only MIE[3] and MPIE[7]; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-005 mepc[1:0] SHALL read 0 regardless of the value written.
REQ-006 A write SHALL take effect at the rising edge where csr_wen_i=1.
REQ-007 Read-after-write bypass: when csr_wen_i=1 and csr_waddr_i[11:0]==csr_raddr_i[11:0] for a writable CSR, csr_rdata_o SHALL equal the masked csr_wdata_i in the same cycle.
REQ-008 On trap_i=1, at the same edge:
- mepc <= trap_pc_i & ~3
- mcause <= trap_cause_i
- MPIE <= MIE
- MIE <= 0
REQ-009 On mret_i=1, at the same edge: MIE <= MPIE, MPIE <= 1.
REQ-010 Priority on the same cycle SHALL be trap_i > mret_i > csr_wen_i, applied per affected field; unaffected CSRs still take the csr_wen_i write.
REQ-011 mcycle SHALL be 64 bits and increment by 1 every cycle out of reset; minstret SHALL be 64 bits and increment by 1 on each cycle with retire_i=1; both SHALL wrap from 2^64-1 to 0.
REQ-012 A software write to either half of a counter SHALL replace that half; that counter SHALL NOT increment on that cycle; the other half SHALL hold.
REQ-013 mtvec_o, mepc_o and mie_o SHALL reflect register state, with no bypass.

Reset
REQ-014 While rst_n=0, asynchronously:
- all writable CSRs and both counters SHALL be 0
- mtvec_o = 0, mepc_o = 0, mie_o = 0
- csr_rdata_o SHALL follow the decode of the reset state
REQ-015 A trap, mret or write coinciding with reset assertion SHALL be discarded.
REQ-016 Counting SHALL start on the first rising edge after rst_n deasserts.

Configuration
REQ-017 Macro CSR_COUNTERS_EN:
- defined: mcycle and minstret with their aliases SHALL be implemented per REQ-011/012
- undefined: no counter flops SHALL exist; all counter addresses SHALL read 0 and ignore writes; retire_i is unused

Verification
REQ-018 Reset release, idle 10 cycles -> mcycle reads 10 (CSR_COUNTERS_EN), mstatus reads 0x00001800, misa reads 0x40000100.
REQ-019 Write mstatus 0xFFFFFFFF with csr_raddr_i=0x300 in the same cycle -> csr_rdata_o = 0x00001888 that cycle; mie_o = 1 next cycle.
REQ-020 MIE=1, MPIE=0; trap_i with trap_pc_i=0x80000106, trap_cause_i=0x8000000B, plus a simultaneous csr write of mepc=0x1234 -> mepc=0x80000104, mcause=0x8000000B, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
REQ-021 Write mcycle=0xFFFFFFFF, mcycleh=0xFFFFFFFF, then idle 1 cycle -> mcycle wraps to 0, mcycleh reads 0.
REQ-022 retire_i high for 5 of 8 cycles -> minstret = 5; write to 0xC02 value 0x55 -> ignored; read of 0x7FF -> 0.
REQ-023 Macro undefined: idle 100 cycles -> reads of 0xB00 and 0xC00 return 0.

Source files
------------

// File: rtl/csr_reg.sv
// csr_reg: machine-mode CSR file with trap/mret handling and a same-cycle
// read-after-write bypass. Reads are combinational; all state updates on the
// rising edge of clk, cleared asynchronously by rst_n.
// Build option: define CSR_COUNTERS_EN to implement the 64-bit mcycle and
// minstret counters and their read-only cycle/instret aliases.
module csr_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wen_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [31:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        retire_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

    // mstatus as software sees it: MPP fixed at machine mode, MIE/MPIE live.
    function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
        return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
    endfunction

    // CSRs that accept software writes (and therefore participate in bypass).
    function automatic logic is_writable(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL: return 1'b1;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Value a write would leave visible, after the per-register field masks.
    function automatic logic [31:0] write_view(input logic [11:0] addr, input logic [31:0] data);
        case (addr)
            ADDR_MSTATUS: return mstatus_view(data[3], data[7]);
            ADDR_MEPC:    return {data[31:2], 2'b00};
            default:      return data;
        endcase
    endfunction

    logic [11:0] waddr;
    logic [11:0] raddr;
    assign waddr = csr_waddr_i[11:0];
    assign raddr = csr_raddr_i[11:0];

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_csr;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [29:0] mepc_hi;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] state_rdata;
    logic        bypass;

    // mstatus.MIE/MPIE: trap beats mret beats a software write.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
        end else if (trap_i) begin
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (mret_i) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (csr_wen_i && waddr == ADDR_MSTATUS) begin
            status_mie  <= csr_wdata_i[3];
            status_mpie <= csr_wdata_i[7];
        end
    end

    // Plain CSRs; a trap overrides software writes to mepc and mcause only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_csr  <= '0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc_hi  <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else begin
            if (csr_wen_i && waddr == ADDR_MIE)      mie_csr  <= csr_wdata_i;
            if (csr_wen_i && waddr == ADDR_MTVEC)    mtvec    <= csr_wdata_i;
            if (csr_wen_i && waddr == ADDR_MSCRATCH) mscratch <= csr_wdata_i;
            if (csr_wen_i && waddr == ADDR_MTVAL)    mtval    <= csr_wdata_i;
            if (trap_i) begin
                mepc_hi <= trap_pc_i[31:2];
                mcause  <= trap_cause_i;
            end else begin
                if (csr_wen_i && waddr == ADDR_MEPC)   mepc_hi <= csr_wdata_i[31:2];
                if (csr_wen_i && waddr == ADDR_MCAUSE) mcause  <= csr_wdata_i;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // Free-running counters; a write to either half replaces it and skips the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_wen_i && waddr == ADDR_MCYCLE)       mcycle[31:0]  <= csr_wdata_i;
            else if (csr_wen_i && waddr == ADDR_MCYCLEH) mcycle[63:32] <= csr_wdata_i;
            else                                         mcycle        <= mcycle + 64'd1;

            if (csr_wen_i && waddr == ADDR_MINSTRET)       minstret[31:0]  <= csr_wdata_i;
            else if (csr_wen_i && waddr == ADDR_MINSTRETH) minstret[63:32] <= csr_wdata_i;
            else if (retire_i)                             minstret        <= minstret + 64'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{csr_waddr_i[31:12], csr_raddr_i[31:12], trap_pc_i[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{csr_waddr_i[31:12], csr_raddr_i[31:12], trap_pc_i[1:0], retire_i};
`endif

    // Read decode of registered state; unmapped addresses read zero.
    always_comb begin
        // NOTE: assign a default first so no path leaves the output unassigned (no latch).
        state_rdata = '0;
        case (raddr)
            ADDR_MSTATUS:  state_rdata = mstatus_view(status_mie, status_mpie);
            ADDR_MISA:     state_rdata = MISA_VALUE;
            ADDR_MIE:      state_rdata = mie_csr;
            ADDR_MTVEC:    state_rdata = mtvec;
            ADDR_MSCRATCH: state_rdata = mscratch;
            ADDR_MEPC:     state_rdata = {mepc_hi, 2'b00};
            ADDR_MCAUSE:   state_rdata = mcause;
            ADDR_MTVAL:    state_rdata = mtval;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,   ADDR_CYCLE:    state_rdata = mcycle[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   state_rdata = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  state_rdata = minstret[31:0];
            ADDR_MINSTRETH,ADDR_INSTRETH: state_rdata = minstret[63:32];
`endif
            default:       state_rdata = '0;
        endcase
    end

    // Forward an in-flight write to the reader; suppressed while in reset.
    assign bypass      = rst_n && csr_wen_i && (waddr == raddr) && is_writable(waddr);
    assign csr_rdata_o = bypass ? write_view(waddr, csr_wdata_i) : state_rdata;

    assign mtvec_o = mtvec;
    assign mepc_o  = {mepc_hi, 2'b00};
    assign mie_o   = status_mie;

endmodule

// File: tb/tb_csr_reg.sv
// tb_csr_reg: directed scenarios followed by randomized traffic, all checked
// against a CSR model kept as plain variables indexed by address.
// Honors CSR_COUNTERS_EN the same way as the design.
module tb_csr_reg;

    logic        clk;
    logic        rst_n;
    logic        csr_wen_i;
    logic [31:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        retire_i;
    logic        trap_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_cause_i;
    logic        mret_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    int checks;
    int errors;

    csr_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_wen_i    (csr_wen_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_raddr_i  (csr_raddr_i),
        .csr_rdata_o  (csr_rdata_o),
        .retire_i     (retire_i),
        .trap_i       (trap_i),
        .trap_pc_i    (trap_pc_i),
        .trap_cause_i (trap_cause_i),
        .mret_i       (mret_i),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_o        (mie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit          m_mie;
    bit          m_mpie;
    logic [31:0] m_miecsr;
    logic [31:0] m_mtvec;
    logic [31:0] m_mscratch;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtval;
    logic [63:0] m_cyc;
    logic [63:0] m_inst;

    localparam int NPOOL = 18;
    logic [11:0] addr_pool [NPOOL] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                       12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                       12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF, 12'h000};

`ifdef CSR_COUNTERS_EN
    localparam bit COUNTERS = 1'b1;
`else
    localparam bit COUNTERS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        m_mie = 0; m_mpie = 0;
        m_miecsr = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_cyc = 0; m_inst = 0;
    endtask

    function automatic logic [31:0] ref_status();
        return 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
    endfunction

    function automatic bit ref_writable(input logic [11:0] a);
        if (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343}) return 1;
        if (COUNTERS && (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82})) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_state_read(input logic [11:0] a);
        case (a)
            12'h300: return ref_status();
            12'h301: return 32'h4000_0100;
            12'h304: return m_miecsr;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return COUNTERS ? m_cyc[31:0]   : 32'h0;
            12'hB80, 12'hC80: return COUNTERS ? m_cyc[63:32]  : 32'h0;
            12'hB02, 12'hC02: return COUNTERS ? m_inst[31:0]  : 32'h0;
            12'hB82, 12'hC82: return COUNTERS ? m_inst[63:32] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // What the read port should show right now, given current inputs.
    function automatic logic [31:0] ref_rdata();
        logic [11:0] wa;
        logic [11:0] ra;
        wa = csr_waddr_i[11:0];
        ra = csr_raddr_i[11:0];
        if (rst_n && csr_wen_i && wa == ra && ref_writable(wa)) begin
            if (wa == 12'h300) return 32'h0000_1800 | (csr_wdata_i & 32'h88);
            if (wa == 12'h341) return csr_wdata_i & ~32'h3;
            return csr_wdata_i;
        end
        return ref_state_read(ra);
    endfunction

    // Apply one rising edge worth of architectural effects.
    task automatic ref_update();
        logic [11:0] wa;
        bit          old_mie;
        bit          old_mpie;
        logic [63:0] n_cyc;
        logic [63:0] n_inst;
        wa = csr_waddr_i[11:0];
        old_mie = m_mie;
        old_mpie = m_mpie;
        n_cyc = m_cyc + 64'd1;
        n_inst = m_inst + (retire_i ? 64'd1 : 64'd0);
        if (csr_wen_i) begin
            case (wa)
                12'h300: if (!trap_i && !mret_i) begin
                    m_mie  = csr_wdata_i[3];
                    m_mpie = csr_wdata_i[7];
                end
                12'h304: m_miecsr   = csr_wdata_i;
                12'h305: m_mtvec    = csr_wdata_i;
                12'h340: m_mscratch = csr_wdata_i;
                12'h341: if (!trap_i) m_mepc = csr_wdata_i & ~32'h3;
                12'h342: if (!trap_i) m_mcause = csr_wdata_i;
                12'h343: m_mtval    = csr_wdata_i;
                12'hB00: n_cyc  = {m_cyc[63:32], csr_wdata_i};
                12'hB80: n_cyc  = {csr_wdata_i, m_cyc[31:0]};
                12'hB02: n_inst = {m_inst[63:32], csr_wdata_i};
                12'hB82: n_inst = {csr_wdata_i, m_inst[31:0]};
                default: ;
            endcase
        end
        if (trap_i) begin
            m_mepc   = trap_pc_i & ~32'h3;
            m_mcause = trap_cause_i;
            m_mpie   = old_mie;
            m_mie    = 0;
        end else if (mret_i) begin
            m_mie  = old_mpie;
            m_mpie = 1;
        end
        m_cyc  = n_cyc;
        m_inst = n_inst;
    endtask

    task automatic tick();
        @(posedge clk);
        ref_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        csr_wen_i = 0; csr_waddr_i = 0; csr_wdata_i = 0; csr_raddr_i = 0;
        retire_i = 0; trap_i = 0; trap_pc_i = 0; trap_cause_i = 0; mret_i = 0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        csr_raddr_i = addr;
        #1;
        check(tag, csr_rdata_o, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] hi;
        logic [7:0]  retire_pattern;
        checks = 0;
        errors = 0;

        // Reset held with every event input active: nothing may leak through.
        rst_n = 0;
        csr_wen_i = 1; csr_waddr_i = 32'h300; csr_wdata_i = 32'hFFFF_FFFF; csr_raddr_i = 32'h300;
        retire_i = 1; trap_i = 1; trap_pc_i = 32'h1234_5678; trap_cause_i = 32'h7; mret_i = 1;
        ref_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_mtvec", mtvec_o, 32'h0);
        check("rst_mepc", mepc_o, 32'h0);
        check("rst_mie", {31'b0, mie_o}, 32'h0);
        check("rst_rdata_mstatus", csr_rdata_o, 32'h0000_1800);
        idle_inputs();
        rst_n = 1;

        // Idle after release: counter starts on the first edge.
        repeat (10) tick();
        read_check("idle_mcycle", 32'hB00, COUNTERS ? 32'd10 : 32'd0);
        read_check("idle_mstatus", 32'h300, 32'h0000_1800);
        read_check("idle_misa", 32'h301, 32'h4000_0100);
`ifndef CSR_COUNTERS_EN
        repeat (100) tick();
        read_check("nocnt_b00", 32'hB00, 32'h0);
        read_check("nocnt_c00", 32'hC00, 32'h0);
`endif

        // Same-cycle bypass of a masked mstatus write; mie_o only after the edge.
        csr_wen_i = 1; csr_waddr_i = 32'h300; csr_wdata_i = 32'hFFFF_FFFF;
        read_check("bypass_mstatus", 32'h300, 32'h0000_1888);
        check("mie_no_bypass", {31'b0, mie_o}, 32'h0);
        tick();
        #1;
        check("mie_after_write", {31'b0, mie_o}, 32'h1);

        // MIE=1, MPIE=0, then a trap that collides with a mepc write.
        csr_wdata_i = 32'h0000_0008;
        tick();
        csr_wen_i = 0;
        read_check("mstatus_mie_only", 32'h300, 32'h0000_1808);
        csr_wen_i = 1; csr_waddr_i = 32'h341; csr_wdata_i = 32'h1234;
        trap_i = 1; trap_pc_i = 32'h8000_0106; trap_cause_i = 32'h8000_000B;
        tick();
        idle_inputs();
        #1;
        check("trap_mepc_o", mepc_o, 32'h8000_0104);
        read_check("trap_mcause", 32'h342, 32'h8000_000B);
        read_check("trap_mstatus", 32'h300, 32'h0000_1880);
        check("trap_mie_o", {31'b0, mie_o}, 32'h0);
        mret_i = 1;
        tick();
        mret_i = 0;
        read_check("mret_mstatus", 32'h300, 32'h0000_1888);
        check("mret_mie_o", {31'b0, mie_o}, 32'h1);

        // 64-bit wrap of mcycle built from two half writes.
        csr_wen_i = 1; csr_waddr_i = 32'hB00; csr_wdata_i = 32'hFFFF_FFFF;
        tick();
        csr_waddr_i = 32'hB80;
        tick();
        csr_wen_i = 0;
        read_check("mcycle_preset_lo", 32'hB00, COUNTERS ? 32'hFFFF_FFFF : 32'h0);
        read_check("mcycle_preset_hi", 32'hB80, COUNTERS ? 32'hFFFF_FFFF : 32'h0);
        tick();
        read_check("mcycle_wrap_lo", 32'hB00, 32'h0);
        read_check("mcycle_wrap_hi", 32'hB80, 32'h0);
        read_check("cycleh_alias", 32'hC80, 32'h0);

        // Retire 5 of 8 cycles; read-only alias and unmapped address ignore writes.
        retire_pattern = 8'b1011_0101;
        for (int i = 0; i < 8; i++) begin
            retire_i = retire_pattern[i];
            tick();
        end
        retire_i = 0;
        read_check("minstret_5", 32'hB02, COUNTERS ? 32'd5 : 32'd0);
        csr_wen_i = 1; csr_waddr_i = 32'hC02; csr_wdata_i = 32'h55;
        read_check("instret_ro_bypass", 32'hC02, COUNTERS ? 32'd5 : 32'd0);
        tick();
        csr_wen_i = 0;
        read_check("instret_ro", 32'hC02, COUNTERS ? 32'd5 : 32'd0);
        csr_wen_i = 1; csr_waddr_i = 32'h7FF; csr_wdata_i = 32'hDEAD_BEEF;
        read_check("unmapped_7ff", 32'h7FF, 32'h0);
        tick();
        csr_waddr_i = 32'h301;
        tick();
        csr_wen_i = 0;
        read_check("misa_ro", 32'h301, 32'h4000_0100);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom();
            hi = $urandom();
            csr_wen_i    = r[0];
            retire_i     = r[1];
            trap_i       = (r[4:2] == 3'd0);
            mret_i       = (r[7:5] == 3'd0);
            csr_waddr_i  = {hi[19:0], addr_pool[$urandom_range(0, NPOOL - 1)]};
            csr_wdata_i  = $urandom();
            csr_raddr_i  = r[8] ? {hi[31:12], csr_waddr_i[11:0]}
                                : {hi[31:12], addr_pool[$urandom_range(0, NPOOL - 1)]};
            trap_pc_i    = $urandom();
            trap_cause_i = $urandom();
            #1;
            check("rand_rdata", csr_rdata_o, ref_rdata());
            check("rand_mtvec", mtvec_o, m_mtvec);
            check("rand_mepc", mepc_o, m_mepc);
            check("rand_mie", {31'b0, mie_o}, {31'b0, m_mie});
            tick();
        end

        // Asynchronous reset mid-cycle with events pending.
        csr_wen_i = 1; csr_waddr_i = 32'h300; csr_wdata_i = 32'hFFFF_FFFF; csr_raddr_i = 32'h300;
        trap_i = 1; mret_i = 1; retire_i = 1;
        #2;
        rst_n = 0;
        #1;
        ref_reset();
        check("arst_mtvec", mtvec_o, 32'h0);
        check("arst_mepc", mepc_o, 32'h0);
        check("arst_mie", {31'b0, mie_o}, 32'h0);
        check("arst_rdata", csr_rdata_o, 32'h0000_1800);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        repeat (3) tick();
        read_check("post_arst_mcycle", 32'hB00, ref_state_read(12'hB00));
        read_check("post_arst_mcycle_val", 32'hC00, COUNTERS ? 32'd3 : 32'd0);
        read_check("post_arst_mstatus", 32'h300, 32'h0000_1800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
